// File: rtl/led_seq_pkg.sv
// Shared mode encoding, LED width and pattern helpers for the LED sequencer.
// Latency: combinational helpers only; no backpressure.
package led_seq_pkg;

  localparam int LED_W = 4;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  function automatic mode_e next_mode(input mode_e mode);
    mode_e nxt;
    case (mode)
      MODE_OFF:   nxt = MODE_BLINK;
      MODE_BLINK: nxt = MODE_CHASE;
      MODE_CHASE: nxt = MODE_COUNT;
      default:    nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

  function automatic logic [LED_W-1:0] led_decode(input mode_e mode, input logic [3:0] step);
    logic [LED_W-1:0] pat;
    case (mode)
      MODE_BLINK: pat = {LED_W{step[0]}};
      MODE_CHASE: pat = LED_W'(1) << step[1:0];
      MODE_COUNT: pat = step[LED_W-1:0];
      default:    pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw button, emitting a pulse on each debounced press.
// Latency: press pulse DB+2 cycles after the raw edge; no backpressure.
module button_debounce #(
  parameter int DB = 10
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int             CW       = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB - 1);

  logic          sync_1;
  logic          sync_2;
  logic [1:0]    sync_vld;
  logic          armed;
  logic [CW-1:0] stable_cnt;
  logic          update;

  assign update = (sync_2 != level) && (stable_cnt == CNT_LAST);

  // A button already high at reset release must be seen low (through a filled
  // synchronizer) before any press can be reported.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      sync_vld   <= 2'b00;
      armed      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync_1   <= raw;
      sync_2   <= sync_1;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !sync_2 && !level) begin
        armed <= 1'b1;
      end
      press <= update && sync_2 && armed;
      if (sync_2 == level) begin
        stable_cnt <= '0;
      end else if (update) begin
        level      <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Button-driven mode FSM stepping a 4-LED pattern at STEP_HZ.
// Latency: LEDs and mode update on the same edge as the state; no backpressure.
module led_pattern_sequencer #(
  parameter int CLK_HZ      = 25000000,
  parameter int STEP_HZ     = 4,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Switch_1,
  output logic [1:0] o_Mode,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  import led_seq_pkg::*;

  localparam int            DIV       = CLK_HZ / STEP_HZ;
  localparam int            DB        = (CLK_HZ * DEBOUNCE_MS) / 1000;
  localparam int            TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("led_pattern_sequencer: CLK_HZ/STEP_HZ must be at least 2");
    end
    if (DB < 1) begin : g_bad_db
      $error("led_pattern_sequencer: debounce window must be at least one cycle");
    end
  endgenerate

  logic             btn_level;
  logic             btn_press;
  logic             press_go;
  logic [TW-1:0]    tick_cnt;
  logic [TW-1:0]    cnt_nxt;
  logic             tick;
  mode_e            mode;
  mode_e            mode_nxt;
  logic [3:0]       step;
  logic [3:0]       step_nxt;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_nxt;

  button_debounce #(.DB(DB)) u_button_debounce (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .raw     (i_Switch_1),
    .level   (btn_level),
    .press   (btn_press)
  );

  assign press_go = btn_press && btn_level;
  assign tick     = (tick_cnt == TICK_LAST);

  // A press restarts the step timebase and wins over a coincident tick.
  always_comb begin
    mode_nxt = mode;
    step_nxt = step;
    cnt_nxt  = tick ? '0 : tick_cnt + TW'(1);
    if (press_go) begin
      mode_nxt = next_mode(mode);
      step_nxt = '0;
      cnt_nxt  = '0;
    end else if (tick && (mode != MODE_OFF)) begin
      step_nxt = step + 4'd1;
    end
    led_nxt = led_decode(mode_nxt, step_nxt);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tick_cnt <= '0;
      mode     <= MODE_OFF;
      step     <= '0;
      led_q    <= '0;
    end else begin
      tick_cnt <= cnt_nxt;
      mode     <= mode_nxt;
      step     <= step_nxt;
      led_q    <= led_nxt;
    end
  end

  assign o_Mode  = mode;
  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with DIV=10 and DB=10.
module tb_led_pattern_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_Switch_1;
  logic [1:0] o_Mode;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       btn;
    int         adv;
    logic [1:0] mode;
    logic [3:0] led;
  } vec_t;

  vec_t vecs[20];

  always #5 i_Clk = ~i_Clk;

  led_pattern_sequencer #(
    .CLK_HZ      (1000),
    .STEP_HZ     (100),
    .DEBOUNCE_MS (10)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Switch_1 (i_Switch_1),
    .o_Mode     (o_Mode),
    .o_LED_1    (o_LED_1),
    .o_LED_2    (o_LED_2),
    .o_LED_3    (o_LED_3),
    .o_LED_4    (o_LED_4)
  );

  task automatic adv(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] m, input logic [3:0] l);
    logic [3:0] leds;
    leds = {o_LED_4, o_LED_3, o_LED_2, o_LED_1};
    n_checks++;
    if (o_Mode !== m || leds !== l) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d leds=%b, expected mode=%0d leds=%b", name, o_Mode, leds, m, l);
    end
  endtask

  task automatic chk_mode(input string name, input logic [1:0] m);
    n_checks++;
    if (o_Mode !== m) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d, expected mode=%0d", name, o_Mode, m);
    end
  endtask

  // Clean press: mode must hold for 12 edges and change on the 13th.
  task automatic press(input string name, input logic [1:0] from_m, input logic [1:0] to_m,
                       input logic [3:0] to_l);
    i_Switch_1 = 1'b1;
    adv(12);
    chk_mode({name, "_before"}, from_m);
    adv(1);
    chk({name, "_edge"}, to_m, to_l);
    i_Switch_1 = 1'b0;
    adv(15);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 12,  2'd0, 4'b0000};
    vecs[1]  = '{1'b1, 1,   2'd1, 4'b0000};
    vecs[2]  = '{1'b1, 9,   2'd1, 4'b0000};
    vecs[3]  = '{1'b1, 1,   2'd1, 4'b1111};
    vecs[4]  = '{1'b1, 7,   2'd1, 4'b1111};
    vecs[5]  = '{1'b0, 3,   2'd1, 4'b0000};
    vecs[6]  = '{1'b0, 10,  2'd1, 4'b1111};
    vecs[7]  = '{1'b1, 13,  2'd2, 4'b0001};
    vecs[8]  = '{1'b1, 10,  2'd2, 4'b0010};
    vecs[9]  = '{1'b0, 10,  2'd2, 4'b0100};
    vecs[10] = '{1'b0, 10,  2'd2, 4'b1000};
    vecs[11] = '{1'b0, 10,  2'd2, 4'b0001};
    vecs[12] = '{1'b1, 13,  2'd3, 4'b0000};
    vecs[13] = '{1'b0, 10,  2'd3, 4'b0001};
    vecs[14] = '{1'b0, 40,  2'd3, 4'b0101};
    vecs[15] = '{1'b0, 100, 2'd3, 4'b1111};
    vecs[16] = '{1'b0, 10,  2'd3, 4'b0000};
    vecs[17] = '{1'b1, 12,  2'd3, 4'b0001};
    vecs[18] = '{1'b1, 1,   2'd0, 4'b0000};
    vecs[19] = '{1'b0, 50,  2'd0, 4'b0000};

    i_Rst_n    = 1'b0;
    i_Switch_1 = 1'b0;
    repeat (3) @(posedge i_Clk);
    #1;
    chk("reset_state", 2'd0, 4'b0000);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    adv(1);

    for (int i = 0; i < 100; i++) begin
      chk("idle", 2'd0, 4'b0000);
      adv(1);
    end

    // Raw input toggling every 3 cycles never stays stable long enough.
    for (int i = 0; i < 50; i++) begin
      i_Switch_1 = (i < 30) ? (((i / 3) % 2) == 0) : 1'b0;
      adv(1);
      chk("bounce", 2'd0, 4'b0000);
    end

    for (int i = 0; i < 20; i++) begin
      i_Switch_1 = vecs[i].btn;
      adv(vecs[i].adv);
      chk($sformatf("vec%0d", i), vecs[i].mode, vecs[i].led);
    end

    // Press lands exactly on the tick that would move COUNT from step 5 to 6.
    press("to_blink", 2'd0, 2'd1, 4'b0000);
    press("to_chase", 2'd1, 2'd2, 4'b0001);
    press("to_count", 2'd2, 2'd3, 4'b0000);
    adv(32);
    i_Switch_1 = 1'b1;
    adv(12);
    chk("tick_press_pre", 2'd3, 4'b0101);
    adv(1);
    chk("tick_press", 2'd0, 4'b0000);
    i_Switch_1 = 1'b0;
    adv(10);
    chk("tick_press_hold", 2'd0, 4'b0000);
    adv(5);

    // Asynchronous reset in CHASE at step 2 while the button is held.
    press("rst_blink", 2'd0, 2'd1, 4'b0000);
    chk("blink_from_step0", 2'd1, 4'b1111);
    press("rst_chase", 2'd1, 2'd2, 4'b0001);
    adv(5);
    chk("chase_step2", 2'd2, 4'b0100);
    i_Switch_1 = 1'b1;
    adv(3);
    chk("chase_step2_held", 2'd2, 4'b0100);
    #3;
    i_Rst_n = 1'b0;
    #1;
    chk("async_reset", 2'd0, 4'b0000);
    adv(1);
    chk("reset_hold", 2'd0, 4'b0000);
    #3;
    i_Rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      adv(1);
      chk("held_after_reset", 2'd0, 4'b0000);
    end
    i_Switch_1 = 1'b0;
    adv(15);
    press("rearm", 2'd0, 2'd1, 4'b0000);
    chk("rearm_blink", 2'd1, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 4, pattern step rate in Hz.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 10, button stable time in ms.
REQ-004 SHALL have port i_Clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_Rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port i_Switch_1, input, 1, raw asynchronous mode-advance button, active-high.
REQ-007 SHALL have port o_Mode, output, 2, current mode encoding.
REQ-008 SHALL have ports o_LED_1..o_LED_4, output, 1 each, registered LED drives; LED_1 = pattern bit 0.

Function
REQ-009 SHALL derive DIV = CLK_HZ/STEP_HZ and DB = CLK_HZ*DEBOUNCE_MS/1000 at elaboration; counter widths = $clog2 of each; elaboration error if DIV < 2 or DB < 1.
REQ-010 SHALL run a tick counter 0..DIV-1, wrapping to 0, asserting a one-cycle tick when counter == DIV-1.
REQ-011 SHALL pass i_Switch_1 through a 2-flop synchronizer before any other use.
REQ-012 SHALL update the debounced level only after the synchronized input differs from it for DB consecutive cycles; any reversion clears the stable count.
REQ-013 SHALL generate a one-cycle press pulse on each 0->1 transition of the debounced level; release generates nothing.
REQ-014 SHALL implement mode FSM OFF(0) -> BLINK(1) -> CHASE(2) -> COUNT(3) -> OFF(0), advancing one state per press pulse; no other transitions.
REQ-015 SHALL hold a 4-bit step register incrementing mod 16 on each tick in BLINK, CHASE, COUNT; held at 0 in OFF.
REQ-016 SHALL, on a press pulse, clear step and tick counter on the same edge the mode changes, so the first step of the new mode occurs DIV cycles later.
REQ-017 SHALL give press priority over a coincident tick: tick discarded, step cleared.
REQ-018 SHALL decode the LED pattern: OFF = 0000; BLINK = all four equal step[0]; CHASE = one-hot 1<<step[1:0]; COUNT = step[3:0].
REQ-019 SHALL register LEDs from next-state mode/step, so LEDs and o_Mode change on the same edge as the mode/step registers (no additional cycle).
REQ-020 SHALL recognize a clean raw press (held > DB+3 cycles) with mode change within DB+4 cycles of the raw rising edge.
REQ-021 SHALL ignore a button held indefinitely after its first press (exactly one advance per press).

Reset
REQ-022 SHALL, on i_Rst_n low, immediately clear: synchronizer flops, debounced level, stable count, tick counter, step, mode = OFF, all LEDs = 0, o_Mode = 0.
REQ-023 SHALL, on reset assertion mid-pattern or mid-debounce, discard all progress; no press is recognized from a button already high at reset release until it is released and pressed again after debounce.

Structure
REQ-024 SHALL place mode enum (OFF, BLINK, CHASE, COUNT, 2-bit) and LED width constant (4) in shared package led_seq_pkg.
REQ-025 SHALL implement synchronizer + debouncer + edge detect as sub-module button_debounce (params DB; ports clock, reset, raw in, level out, press pulse out); tick counter and FSM stay in the top.

Verification (CLK_HZ=1000, STEP_HZ=100 -> DIV=10; DEBOUNCE_MS=10 -> DB=10)
REQ-026 Reset release, no button for 100 cycles -> o_Mode=0, LEDs 0000 throughout.
REQ-027 One clean press (held 30 cycles) -> o_Mode=1 within 14 cycles; LEDs 0000 then 1111 10 cycles after mode change, toggling every 10 cycles.
REQ-028 Bounce: raw toggles every 3 cycles for 30 cycles, then low -> no mode change; 4 clean presses -> modes 1,2,3,0; CHASE shows 0001,0010,0100,1000,0001 every 10 cycles; COUNT shows 0000..1111 then wraps to 0000 at step 16.
REQ-029 Press pulse timed coincident with tick in COUNT at step 5 -> mode 0, LEDs 0000, step 0, no increment.
REQ-030 i_Rst_n pulsed low asynchronously (mid-cycle) in CHASE at step 2 with button held -> LEDs/o_Mode 0 immediately; after release, held button causes no advance until released and re-pressed.
